// File: rtl/game_pkg.sv
// Shared playfield constants, direction type and clamped-step helper
// for the player motion datapath.
package game_pkg;

  localparam int DEF_RADIUS = 35;
  localparam int DEF_X_MIN  = 0;
  localparam int DEF_X_MAX  = 639;
  localparam int DEF_Y_MIN  = 0;
  localparam int DEF_Y_MAX  = 479;

  localparam int DEF_XLO = DEF_X_MIN + DEF_RADIUS;
  localparam int DEF_XHI = DEF_X_MAX - DEF_RADIUS;
  localparam int DEF_YLO = DEF_Y_MIN + DEF_RADIUS;
  localparam int DEF_YHI = DEF_Y_MAX - DEF_RADIUS;

  typedef enum logic [1:0] {
    HOLD,
    DEC,
    INC
  } dir_t;

  // Distance-to-bound form keeps the result inside [lo,hi] without wrap.
  function automatic int clamp_step(
    input int   pos,
    input dir_t dir,
    input int   lo,
    input int   hi,
    input int   step
  );
    int r;
    r = pos;
    unique case (dir)
      DEC:     r = (pos - lo < step) ? lo : pos - step;
      INC:     r = (hi - pos < step) ? hi : pos + step;
      default: r = pos;
    endcase
    return r;
  endfunction

  function automatic int clamp_init(
    input int v,
    input int lo,
    input int hi
  );
    int r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// One axis of one player: button sync, direction decode,
// clamped working position and frame-aligned display shadow.
module axis_stepper
  import game_pkg::*;
#(
  parameter int POS_W = 10,
  parameter int LO    = 35,
  parameter int HI    = 604,
  parameter int STEP  = 1,
  parameter int INIT  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_dec,
  input  logic             btn_inc,
  input  logic             move_tick,
  input  logic             frame_start,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] INIT_C =
    POS_W'(clamp_init(INIT, LO, HI));

  logic [1:0]       dec_s;
  logic [1:0]       inc_s;
  logic [POS_W-1:0] work;
  dir_t             dir;

  always_comb begin
    dir = HOLD;
    unique case (1'b1)
      dec_s[1] && !inc_s[1]: dir = DEC;
      inc_s[1] && !dec_s[1]: dir = INC;
      default:               dir = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_s <= '0;
      inc_s <= '0;
      work  <= INIT_C;
      pos   <= INIT_C;
    end else begin
      dec_s <= {dec_s[0], btn_dec};
      inc_s <= {inc_s[0], btn_inc};
      if (move_tick)
        work <= POS_W'(clamp_step(int'(work), dir, LO, HI, STEP));
      // shadow samples pre-tick work when both fire together
      if (frame_start)
        pos <= work;
    end
  end

endmodule

// File: rtl/player_motion_controller.sv
// N-player motion controller: shared movement tick plus one
// axis_stepper per player per axis, in the vga clock domain.
module player_motion_controller
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int POS_W          = 10,
  parameter int PLAYER_RADIUS  = DEF_RADIUS,
  parameter int FIELD_X_MIN    = DEF_X_MIN,
  parameter int FIELD_X_MAX    = DEF_X_MAX,
  parameter int FIELD_Y_MIN    = DEF_Y_MIN,
  parameter int FIELD_Y_MAX    = DEF_Y_MAX,
  parameter int INIT_X_BASE    = 100,
  parameter int INIT_X_SPACING = 400,
  parameter int INIT_Y         = 250,
  parameter int MOVE_PERIOD    = 100000,
  parameter int STEP           = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PLAYERS-1:0]       btn_up,
  input  logic [NUM_PLAYERS-1:0]       btn_down,
  input  logic [NUM_PLAYERS-1:0]       btn_left,
  input  logic [NUM_PLAYERS-1:0]       btn_right,
  input  logic                         pause,
  input  logic                         frame_start,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_x,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_y,
  output logic                         move_tick
);

  localparam int X_LO = FIELD_X_MIN + PLAYER_RADIUS;
  localparam int X_HI = FIELD_X_MAX - PLAYER_RADIUS;
  localparam int Y_LO = FIELD_Y_MIN + PLAYER_RADIUS;
  localparam int Y_HI = FIELD_Y_MAX - PLAYER_RADIUS;
  localparam int CW   = $clog2(MOVE_PERIOD);

  logic [CW-1:0] cnt;

  assign move_tick = !pause && (cnt == CW'(MOVE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!pause) begin
      if (cnt == CW'(MOVE_PERIOD - 1))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    axis_stepper #(
      .POS_W (POS_W),
      .LO    (X_LO),
      .HI    (X_HI),
      .STEP  (STEP),
      .INIT  (INIT_X_BASE + i * INIT_X_SPACING)
    ) u_x (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_dec     (btn_left[i]),
      .btn_inc     (btn_right[i]),
      .move_tick   (move_tick),
      .frame_start (frame_start),
      .pos         (pos_x[i*POS_W +: POS_W])
    );

    axis_stepper #(
      .POS_W (POS_W),
      .LO    (Y_LO),
      .HI    (Y_HI),
      .STEP  (STEP),
      .INIT  (INIT_Y)
    ) u_y (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_dec     (btn_up[i]),
      .btn_inc     (btn_down[i]),
      .move_tick   (move_tick),
      .frame_start (frame_start),
      .pos         (pos_y[i*POS_W +: POS_W])
    );
  end

endmodule

// File: tb/tb_player_motion_controller.sv
// Scoreboard bench: dut_a (period 4, step 1) and dut_b (step 7,
// player 1 starting near the right edge).
module tb_player_motion_controller;

  localparam int NP = 2;
  localparam int W  = 10;

  logic clk = 0;
  logic rst_n = 1;
  logic pause = 0;
  logic frame_start = 0;

  logic [NP-1:0] a_up = '0, a_dn = '0, a_lf = '0, a_rt = '0;
  logic [NP-1:0] b_up = '0, b_dn = '0, b_lf = '0, b_rt = '0;
  logic [NP*W-1:0] a_x, a_y, b_x, b_y;
  logic a_tick, b_tick;

  always #5 clk = ~clk;

  player_motion_controller #(
    .NUM_PLAYERS (NP),
    .MOVE_PERIOD (4)
  ) dut_a (
    .clk (clk), .rst_n (rst_n),
    .btn_up (a_up), .btn_down (a_dn),
    .btn_left (a_lf), .btn_right (a_rt),
    .pause (pause), .frame_start (frame_start),
    .pos_x (a_x), .pos_y (a_y), .move_tick (a_tick)
  );

  player_motion_controller #(
    .NUM_PLAYERS    (NP),
    .MOVE_PERIOD    (4),
    .STEP           (7),
    .INIT_X_SPACING (500)
  ) dut_b (
    .clk (clk), .rst_n (rst_n),
    .btn_up (b_up), .btn_down (b_dn),
    .btn_left (b_lf), .btn_right (b_rt),
    .pause (pause), .frame_start (frame_start),
    .pos_x (b_x), .pos_y (b_y), .move_tick (b_tick)
  );

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_pos(input int sel);
    case (sel)
      0:       return int'(a_x[0 +: W]);
      1:       return int'(a_x[W +: W]);
      2:       return int'(a_y[0 +: W]);
      3:       return int'(a_y[W +: W]);
      4:       return int'(b_x[0 +: W]);
      5:       return int'(b_x[W +: W]);
      6:       return int'(b_y[0 +: W]);
      default: return int'(b_y[W +: W]);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, get_pos(e.sel), e.exp);
    end
  endtask

  task automatic frame();
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    drain();
  endtask

  // returns at the negedge just after the tick has been consumed
  task automatic wait_tick(input bit b);
    int n;
    n = 0;
    while (!(b ? b_tick : a_tick)) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        check("tick_timeout", 0, 1);
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic push_init();
    push("init_ax0", 0, 100);
    push("init_ax1", 1, 500);
    push("init_ay0", 2, 250);
    push("init_ay1", 3, 250);
    push("init_bx0", 4, 100);
    push("init_bx1", 5, 600);
    push("init_by0", 6, 250);
    push("init_by1", 7, 250);
  endtask

  initial begin
    int n, bad, ey, ex;
    int bx0, bx1;

    #2 rst_n = 0;
    #1;
    push_init();
    drain();
    check("reset_tick", int'(a_tick), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int f = 0; f < 3; f++) begin
      push("idle_ax0", 0, 100);
      push("idle_ax1", 1, 500);
      push("idle_ay0", 2, 250);
      push("idle_ay1", 3, 250);
      frame();
    end

    wait_tick(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_tick && n < 50);
    check("tick_period", n + 1, 4);

    // player 0 up until clamped at YLO = 35
    wait_tick(0);
    a_up[0] = 1;
    ey = 250;
    for (int k = 0; k < 225; k++) begin
      wait_tick(0);
      ey = (ey > 35) ? ey - 1 : 35;
      push("up_y0", 2, ey);
      frame();
    end
    push("up_x0", 0, 100);
    push("up_y1", 3, 250);
    drain();

    a_dn[0] = 1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(0);
      push("updn_y0", 2, 35);
      frame();
    end

    a_up[0] = 0;
    a_lf[0] = 1;
    ex = 100;
    for (int k = 0; k < 3; k++) begin
      wait_tick(0);
      ex--;
      ey++;
      push("diag_x0", 0, ex);
      push("diag_y0", 2, ey);
      push("diag_x1", 1, 500);
      frame();
    end
    a_lf = '0;
    a_dn = '0;

    // pause while the count sits at 2
    wait_tick(0);
    @(negedge clk);
    @(negedge clk);
    pause = 1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_tick) bad++;
    end
    check("pause_no_tick", bad, 0);
    pause = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_tick && n < 50);
    check("pause_resume", n + 1, 4 - 2);

    // frame_start coincident with move_tick
    wait_tick(0);
    a_dn[0] = 1;
    n = 0;
    while (!a_tick && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("coinc_tick_seen", int'(a_tick), 1);
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    push("coinc_old_y0", 2, ey);
    drain();
    push("coinc_new_y0", 2, ey + 1);
    frame();
    a_dn = '0;

    // step 7 near both x bounds
    wait_tick(1);
    b_rt[1] = 1;
    b_lf[0] = 1;
    bx0 = 100;
    bx1 = 600;
    for (int k = 0; k < 12; k++) begin
      wait_tick(1);
      bx1 = (bx1 + 7 > 604) ? 604 : bx1 + 7;
      bx0 = (bx0 - 7 < 35) ? 35 : bx0 - 7;
      push("step7_x1", 5, bx1);
      push("step7_x0", 4, bx0);
      push("step7_y1", 7, 250);
      frame();
    end

    // asynchronous reset mid-frame
    #2 rst_n = 0;
    #1;
    push_init();
    drain();
    check("midrst_tick", int'(a_tick), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_motion_controller.md
Name: player_motion_controller

Overview:
- Parametrised successor to the two-team game_controller: drives N players, each with up/down/left/right buttons. The old block had vertical motion only for two teams.
- Synchronises the raw buttons and steps positions on a shared movement tick, clamping each position to the playfield inset by the player radius.
- Publishes the positions to vga_controller through frame-aligned shadow registers, so a frame never shows a position that changed mid-scan.
- Sits between the board buttons and vga_controller, in the vga_clk domain.

Parameters:
- NUM_PLAYERS, 2, number of independent players (1..8).
- POS_W, 10, width of each coordinate.
- PLAYER_RADIUS, 35, half-size of a player; clamp inset.
- FIELD_X_MIN / FIELD_X_MAX, 0 / 639, playfield horizontal bounds (inclusive).
- FIELD_Y_MIN / FIELD_Y_MAX, 0 / 479, playfield vertical bounds (inclusive).
- INIT_X_BASE, 100, initial x of player 0.
- INIT_X_SPACING, 400, x offset between consecutive players.
- INIT_Y, 250, initial y of all players.
- MOVE_PERIOD, 100000, clocks per movement tick (≥2).
- STEP, 1, pixels moved per tick per axis.

Ports:
- clk  in  1  pixel/vga clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_up  in  NUM_PLAYERS  raw, asynchronous, active-high; bit i = player i (same for the three below).
- btn_down  in  NUM_PLAYERS  raw.
- btn_left  in  NUM_PLAYERS  raw.
- btn_right  in  NUM_PLAYERS  raw.
- pause  in  1  synchronous; freezes motion while high.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pos_x  out  NUM_PLAYERS*POS_W  displayed x; player i in bits [i*POS_W +: POS_W].
- pos_y  out  NUM_PLAYERS*POS_W  displayed y, same packing.
- move_tick  out  1  one-cycle pulse each movement tick (debug).

Behaviour:
- Reset (async assert, sync-release usage): tick counter = 0, move_tick = 0, all synchronisers = 0.
  - Working and displayed x[i] = INIT_X_BASE + i*INIT_X_SPACING; y[i] = INIT_Y.
  - Initial values outside the clamp window are clamped at elaboration.
- Inputs: every button passes a 2-FF synchroniser. Button-to-motion latency is 2 cycles plus the wait to the next tick.
- Tick counter: counts 0..MOVE_PERIOD-1 and wraps. move_tick = 1 for exactly the cycle count == MOVE_PERIOD-1.
  - While pause = 1 the counter holds and move_tick = 0. Release resumes from the held count.
- Clamp window: XLO = FIELD_X_MIN + PLAYER_RADIUS, XHI = FIELD_X_MAX - PLAYER_RADIUS; YLO / YHI likewise.
- On move_tick, per player, per axis, independently:
  - up only: y ← (y - YLO < STEP) ? YLO : y - STEP.
  - down only: y ← (YHI - y < STEP) ? YHI : y + STEP.
  - left / right: same rule on x.
  - Both buttons of an axis, or neither: no change on that axis.
  - Diagonal (one button on each axis) moves both axes in the same tick.
- Arithmetic: internal math is POS_W+1 bits. The comparison form above guarantees no wrap at 0 or 2^POS_W-1.
- Working positions update only on move_tick. They are registered and valid the cycle after the tick.
- Display shadow: on frame_start, pos_x/pos_y ← working positions. At all other times they hold.
  - If frame_start and move_tick occur in the same cycle, the shadow takes the pre-tick working value; the update appears at the next frame_start.
  - pause does not block shadow updates.
- Reset mid-operation: everything returns to reset values immediately. Displayed positions show initial values without waiting for frame_start.
- Player state: per-player per-axis state is {HOLD, DEC, INC}, decoded combinationally from the synchronised buttons. No latent state persists between ticks.

Decomposition:
- Shared package game_pkg holds:
  - the field and radius defaults and the clamp-window constants;
  - a function clamp_step(pos, dir, lo, hi, step) returning POS_W bits;
  - the dir_t enum {HOLD, DEC, INC}.
- Sub-module axis_stepper, instantiated 2*NUM_PLAYERS times: synchronisers for one button pair, dir decode, clamp_step register, shadow register.
- Top level: tick counter plus generate loop.

Test Plan:
- Reset release, no buttons, 3 frame_start pulses (defaults) → pos_x = {500,100}, pos_y = {250,250} constant; move_tick every 100000 clocks.
- MOVE_PERIOD = 4, player 0 up held, y starting at 250 → working y = 249, 248, … on each tick. Descent stops at exactly 35 and holds for ≥10 more ticks.
- STEP = 7, player 1 right held, x near XHI = 604, starting x = 600 → next tick x = 604, not 607; no wrap.
- Player 0 up+down held, and left+down held → no y change on the up+down case; left+down gives x-1, y+1 per tick.
- pause high for 20 clocks mid-count at count = 2 → no move_tick during pause; next tick lands MOVE_PERIOD-2 clocks after release.
- frame_start coincident with move_tick → pos_y shows the old value; it shows the new value only after the next frame_start. Asserting rst_n = 0 mid-frame → outputs show the initial values asynchronously.
